axis_frame_capture: RTL and testbench
=====================================

Name: axis_frame_capture

Overview:
- AXI-Stream sink that receives the FIR output stream (M_AXIS side of the FIFO/FIR chain) and captures one frame into an on-chip buffer.
- Hardware receive-end counterpart of the impulse-stimulus source. Lets an on-board controller arm a capture and read back the impulse response.
- Computes per-frame beat count, peak magnitude and signed sum, and flags overflow.
- Single clock domain: the AXIS destination clock.

Parameters:
- DATA_W, 32, stream sample width (signed two's complement).
- DEPTH, 64, capture buffer entries (power of two, ≥ 2).
- ADDR_W, $clog2(DEPTH), buffer address width (derived; do not override).

Ports:
- s_aclk  in  1  clock, all logic on rising edge.
- src_rst  in  1  synchronous active-high reset.
- s_axis_tdata  in  DATA_W  sample.
- s_axis_tvalid  in  1  sample valid.
- s_axis_tready  out  1  sink ready.
- s_axis_tlast  in  1  last beat of frame.
- arm  in  1  single-cycle request to start a capture.
- busy  out  1  high in CAPTURE.
- frame_done  out  1  high in DONE (level).
- frame_len  out  ADDR_W+1  beats stored, saturating at DEPTH.
- overflow  out  1  sticky: frame had more than DEPTH beats.
- peak_abs  out  DATA_W  max |sample| over the frame, unsigned.
- sum  out  DATA_W+ADDR_W+1  signed sum of the stored beats.
- rd_addr  in  ADDR_W  readback address.
- rd_data  out  DATA_W  buffer word; registered, 1-cycle latency.

Behaviour:
- Beat: s_axis_tvalid && s_axis_tready on a rising edge.
- States: IDLE, CAPTURE, DONE.
- Reset, from any state including mid-capture:
  - State goes to IDLE.
  - busy=0, frame_done=0, frame_len=0, overflow=0, peak_abs=0, sum=0, rd_data=0.
  - Buffer contents are undefined after reset.
- IDLE:
  - s_axis_tready=1; beats are accepted and discarded, so upstream never stalls.
  - arm → CAPTURE on the next cycle. Entering CAPTURE clears frame_len, overflow, peak_abs and sum.
- CAPTURE:
  - s_axis_tready=1 (see the optional feature).
  - Each beat with frame_len<DEPTH:
    - Writes buffer[frame_len].
    - frame_len+1.
    - sum += sign-extended tdata.
    - peak_abs = max(peak_abs, |tdata|). |−2^(DATA_W−1)| = 2^(DATA_W−1) and fits unsigned DATA_W.
  - Beat with frame_len==DEPTH: data discarded, overflow=1, frame_len/sum/peak_abs unchanged.
  - Beat with tlast=1:
    - That beat is processed by the same rules, then the state goes to DONE the next cycle.
    - A single-beat frame is legal.
  - arm during CAPTURE is ignored.
  - The first beat in the cycle after arm is captured. A beat in the same cycle as arm, while in IDLE, is discarded.
- DONE:
  - frame_done=1; s_axis_tready=1, beats discarded.
  - Results hold until the next arm.
  - arm → CAPTURE, which clears the results as above.
- Readback:
  - rd_data = buffer[rd_addr] registered; valid in every state.
  - Reading during CAPTURE returns old or new data with no hazard guarantee.
- Arithmetic:
  - sum cannot overflow: DEPTH × 2^(DATA_W−1) fits in DATA_W+ADDR_W+1 signed.
  - frame_len counts only stored beats.
- Buffer: simple dual-port, inferable as distributed or block RAM.

Optional Feature:
- Macro: AXIS_CAPTURE_BACKPRESSURE_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5, loaded on reset) advances every cycle.
  - In CAPTURE, s_axis_tready = (lfsr[1:0] != 2'b00), which exercises upstream FIFO stall handling.
  - IDLE and DONE still drive s_axis_tready=1.
- Undefined: no LFSR logic; s_axis_tready=1 constantly.

Test Plan:
- Impulse: arm, then 32767 followed by 49 zeros, tlast on beat 50 → frame_done=1, frame_len=50, overflow=0, peak_abs=32767, sum=32767; rd_addr 0 → rd_data 32767 next cycle; rd_addr 1..49 → 0.
- Overflow: arm, then 70 beats of value 1, tlast on beat 70 → frame_len=64, overflow=1, sum=64, peak_abs=1.
- Idle discard and arm timing: beats 5,6 sent before arm and a beat 7 coincident with arm are discarded; then 8 with tlast → frame_len=1, rd_data[0]=8, sum=8.
- Negative extremes: arm, then −2^31 and −1 with tlast → peak_abs=32'h8000_0000, sum=−2^31−1 sign-extended, frame_len=2.
- Reset mid-capture: arm, 10 beats, src_rst for 1 cycle → all outputs at reset values, busy=0; re-arm and 3-beat frame → frame_len=3.
- AXIS_CAPTURE_BACKPRESSURE_EN defined: source holds tvalid with an upstream FIFO; 50-beat impulse frame → s_axis_tready toggles per the LFSR, no beats lost or duplicated, same results as the impulse scenario.

Source files
------------

// File: rtl/axis_frame_capture.sv
// AXI-Stream sink that captures one frame into an on-chip buffer with per-frame statistics.
// Optional: define AXIS_CAPTURE_BACKPRESSURE_EN for LFSR-driven tready throttling during capture.
module axis_frame_capture #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                       s_aclk,
  input  logic                       src_rst,
  input  logic [DATA_W-1:0]          s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tlast,
  input  logic                       arm,
  output logic                       busy,
  output logic                       frame_done,
  output logic [ADDR_W:0]            frame_len,
  output logic                       overflow,
  output logic [DATA_W-1:0]          peak_abs,
  output logic [DATA_W+ADDR_W:0]     sum,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic [DATA_W-1:0]          rd_data
);

  localparam int unsigned SumW = DATA_W + ADDR_W + 1;

  typedef enum logic [1:0] {StIdle, StCapture, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W:0]     frame_len_q, frame_len_d;
  logic                overflow_q, overflow_d;
  logic [DATA_W-1:0]   peak_abs_q, peak_abs_d;
  logic [SumW-1:0]     sum_q, sum_d;
  logic [DATA_W-1:0]   rd_data_q;
  logic                wr_en;
  logic                beat;
  logic [DATA_W-1:0]   sample_abs;
  logic [SumW-1:0]     sample_ext;

  logic [DATA_W-1:0]   mem [DEPTH];

`ifdef AXIS_CAPTURE_BACKPRESSURE_EN
  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge s_aclk) begin
    if (src_rst) lfsr_q <= 8'hA5;
    else         lfsr_q <= lfsr_d;
  end

  assign s_axis_tready = (state_q != StCapture) || (lfsr_q[1:0] != 2'b00);
`else
  assign s_axis_tready = 1'b1;
`endif

  assign beat       = s_axis_tvalid && s_axis_tready;
  // Magnitude of the most negative value wraps to 2^(DATA_W-1), which is correct unsigned.
  assign sample_abs = s_axis_tdata[DATA_W-1] ? -s_axis_tdata : s_axis_tdata;
  assign sample_ext = {{(ADDR_W+1){s_axis_tdata[DATA_W-1]}}, s_axis_tdata};

  always_comb begin
    state_d     = state_q;
    frame_len_d = frame_len_q;
    overflow_d  = overflow_q;
    peak_abs_d  = peak_abs_q;
    sum_d       = sum_q;
    wr_en       = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (arm) begin
          state_d     = StCapture;
          frame_len_d = '0;
          overflow_d  = 1'b0;
          peak_abs_d  = '0;
          sum_d       = '0;
        end
      end
      StCapture: begin
        if (beat) begin
          // frame_len saturates at DEPTH (a power of two), so its MSB marks a full buffer.
          if (!frame_len_q[ADDR_W]) begin
            wr_en       = 1'b1;
            frame_len_d = frame_len_q + (ADDR_W+1)'(1);
            sum_d       = sum_q + sample_ext;
            if (sample_abs > peak_abs_q) peak_abs_d = sample_abs;
          end else begin
            overflow_d = 1'b1;
          end
          if (s_axis_tlast) state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge s_aclk) begin
    if (src_rst) begin
      state_q     <= StIdle;
      frame_len_q <= '0;
      overflow_q  <= 1'b0;
      peak_abs_q  <= '0;
      sum_q       <= '0;
    end else begin
      state_q     <= state_d;
      frame_len_q <= frame_len_d;
      overflow_q  <= overflow_d;
      peak_abs_q  <= peak_abs_d;
      sum_q       <= sum_d;
    end
  end

  // Buffer is left unreset so it maps onto RAM primitives.
  always_ff @(posedge s_aclk) begin
    if (wr_en) mem[frame_len_q[ADDR_W-1:0]] <= s_axis_tdata;
  end

  always_ff @(posedge s_aclk) begin
    if (src_rst) rd_data_q <= '0;
    else         rd_data_q <= mem[rd_addr];
  end

  assign busy       = (state_q == StCapture);
  assign frame_done = (state_q == StDone);
  assign frame_len  = frame_len_q;
  assign overflow   = overflow_q;
  assign peak_abs   = peak_abs_q;
  assign sum        = sum_q;
  assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_axis_frame_capture.sv
// Directed self-checking bench for axis_frame_capture (default parameters).
module tb_axis_frame_capture;

  logic        s_aclk = 1'b0;
  logic        src_rst;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic        arm;
  logic        busy;
  logic        frame_done;
  logic [6:0]  frame_len;
  logic        overflow;
  logic [31:0] peak_abs;
  logic [38:0] sum;
  logic [5:0]  rd_addr;
  logic [31:0] rd_data;

  int n_total = 0;
  int n_bad   = 0;

  always #5 s_aclk = ~s_aclk;

  axis_frame_capture dut (
    .s_aclk        (s_aclk),
    .src_rst       (src_rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .arm           (arm),
    .busy          (busy),
    .frame_done    (frame_done),
    .frame_len     (frame_len),
    .overflow      (overflow),
    .peak_abs      (peak_abs),
    .sum           (sum),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sum64();
    return 64'($signed(sum));
  endfunction

  // Holds tvalid until the DUT accepts the beat; tready is sampled at the falling edge.
  task automatic send_beat(input logic [31:0] d, input logic last);
    logic accepted = 1'b0;
    for (int t = 0; t < 100 && !accepted; t++) begin
      @(negedge s_aclk);
      arm           = 1'b0;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d;
      s_axis_tlast  = last;
      accepted      = s_axis_tready;
      @(posedge s_aclk);
    end
    if (!accepted) check_eq("beat_accept", 64'(accepted), 64'd1);
  endtask

  task automatic go_quiet();
    @(negedge s_aclk);
    arm           = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic do_arm(input logic with_beat, input logic [31:0] d);
    @(negedge s_aclk);
    arm           = 1'b1;
    s_axis_tvalid = with_beat;
    s_axis_tdata  = d;
    s_axis_tlast  = 1'b0;
    @(posedge s_aclk);
  endtask

  task automatic read_chk(input string tag, input logic [5:0] a, input logic [31:0] exp);
    @(negedge s_aclk);
    rd_addr = a;
    @(negedge s_aclk);
    check_eq(tag, 64'(rd_data), 64'(exp));
  endtask

  task automatic reset_pulse();
    @(negedge s_aclk);
    src_rst       = 1'b1;
    arm           = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    @(negedge s_aclk);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(frame_done), 64'd0);
    check_eq("rst_len", 64'(frame_len), 64'd0);
    check_eq("rst_ovf", 64'(overflow), 64'd0);
    check_eq("rst_peak", 64'(peak_abs), 64'd0);
    check_eq("rst_sum", sum64(), 64'd0);
    check_eq("rst_rdata", 64'(rd_data), 64'd0);
    src_rst = 1'b0;
  endtask

  initial begin
    src_rst       = 1'b1;
    arm           = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tdata  = '0;
    rd_addr       = '0;
    repeat (2) @(posedge s_aclk);
    reset_pulse();
    @(negedge s_aclk);
    check_eq("idle_tready", 64'(s_axis_tready), 64'd1);

    // Impulse frame
    do_arm(1'b0, 32'd0);
    go_quiet();
    check_eq("imp_busy", 64'(busy), 64'd1);
    send_beat(32'd32767, 1'b0);
    for (int i = 1; i < 50; i++) send_beat(32'd0, i == 49);
    go_quiet();
    check_eq("imp_done", 64'(frame_done), 64'd1);
    check_eq("imp_busy0", 64'(busy), 64'd0);
    check_eq("imp_len", 64'(frame_len), 64'd50);
    check_eq("imp_ovf", 64'(overflow), 64'd0);
    check_eq("imp_peak", 64'(peak_abs), 64'd32767);
    check_eq("imp_sum", sum64(), 64'd32767);
    read_chk("imp_rd0", 6'd0, 32'd32767);
    for (int i = 1; i < 50; i++) read_chk("imp_rdn", 6'(i), 32'd0);
    // Beats in DONE are discarded
    send_beat(32'd99, 1'b1);
    go_quiet();
    check_eq("done_len", 64'(frame_len), 64'd50);
    check_eq("done_sum", sum64(), 64'd32767);
    read_chk("done_rd50", 6'd0, 32'd32767);

    // Overflow frame, with a stray arm mid-frame that must be ignored
    do_arm(1'b0, 32'd0);
    for (int i = 1; i <= 70; i++) begin
      send_beat(32'd1, i == 70);
      if (i == 30) do_arm(1'b0, 32'd0);
    end
    go_quiet();
    check_eq("ovf_done", 64'(frame_done), 64'd1);
    check_eq("ovf_len", 64'(frame_len), 64'd64);
    check_eq("ovf_flag", 64'(overflow), 64'd1);
    check_eq("ovf_sum", sum64(), 64'd64);
    check_eq("ovf_peak", 64'(peak_abs), 64'd1);
    read_chk("ovf_rd63", 6'd63, 32'd1);

    // Idle discard and arm timing
    reset_pulse();
    send_beat(32'd5, 1'b0);
    send_beat(32'd6, 1'b0);
    do_arm(1'b1, 32'd7);
    send_beat(32'd8, 1'b1);
    go_quiet();
    check_eq("arm_len", 64'(frame_len), 64'd1);
    check_eq("arm_sum", sum64(), 64'd8);
    check_eq("arm_peak", 64'(peak_abs), 64'd8);
    read_chk("arm_rd0", 6'd0, 32'd8);

    // Negative extremes
    do_arm(1'b0, 32'd0);
    send_beat(32'h8000_0000, 1'b0);
    send_beat(32'hFFFF_FFFF, 1'b1);
    go_quiet();
    check_eq("neg_len", 64'(frame_len), 64'd2);
    check_eq("neg_peak", 64'(peak_abs), 64'h8000_0000);
    check_eq("neg_sum", sum64(), 64'hFFFF_FFFF_7FFF_FFFF);
    read_chk("neg_rd1", 6'd1, 32'hFFFF_FFFF);

    // Reset mid-capture, then a fresh 3-beat frame
    do_arm(1'b0, 32'd0);
    for (int i = 1; i <= 10; i++) send_beat(32'(i), 1'b0);
    reset_pulse();
    do_arm(1'b0, 32'd0);
    send_beat(32'd2, 1'b0);
    send_beat(32'd3, 1'b0);
    send_beat(32'd4, 1'b1);
    go_quiet();
    check_eq("rr_done", 64'(frame_done), 64'd1);
    check_eq("rr_len", 64'(frame_len), 64'd3);
    check_eq("rr_sum", sum64(), 64'd9);
    check_eq("rr_peak", 64'(peak_abs), 64'd4);
    read_chk("rr_rd2", 6'd2, 32'd4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule
